// File: rtl/cs_pkg.sv
// Shared types and defaults for the CS filter sample-transmit slice.
package cs_pkg;

    localparam int unsigned DATA_W_DEF  = 8;
    localparam int unsigned WIN_DEF     = 9;
    localparam int unsigned FRAME_LEN_W = 8;

    typedef logic [7:0] sample_t;

    typedef enum logic [1:0] {
        IDLE,
        PRIME,
        STREAM,
        FIN
    } tx_state_t;

endpackage

// File: rtl/cs_sample_tx_if.sv
// Host-side and filter-side signal bundle of the sample transmitter.
interface cs_sample_tx_if
    import cs_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF
);

    logic [DATA_W-1:0]      in_data;
    logic                   in_valid;
    logic                   in_ready;
    logic                   start;
    logic [FRAME_LEN_W-1:0] frame_len;
    logic [DATA_W-1:0]      X;
    logic                   x_valid;
    logic                   win_full;
    logic                   busy;
    logic                   done;
    logic                   underrun;

    // Host / environment side.
    modport master (
        output in_data, in_valid, start, frame_len,
        input  in_ready, X, x_valid, win_full, busy, done, underrun
    );

    // Transmitter side.
    modport slave (
        input  in_data, in_valid, start, frame_len,
        output in_ready, X, x_valid, win_full, busy, done, underrun
    );

endinterface

// File: rtl/cs_fifo.sv
// Synchronous first-word-fall-through sample FIFO; DEPTH must be a power of 2.
module cs_fifo #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_data,
    input  logic                     rd_en,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_wr;
    logic              do_rd;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;
    assign rd_data = mem[rd_ptr];

    // Storage array; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally at DEPTH; count tracks occupancy.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_rd) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/cs_sample_tx.sv
// Feeds buffered host samples to the CS filter X input, one per cycle per frame.
module cs_sample_tx
    import cs_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned WIN    = WIN_DEF
) (
    input  logic         clk,
    input  logic         reset,
    cs_sample_tx_if.slave bus
);

    localparam int unsigned CNT_W  = $clog2(DEPTH) + 1;
    localparam int unsigned SENT_W = $clog2(WIN + 1);

    tx_state_t              state;
    tx_state_t              state_d;
    logic [FRAME_LEN_W-1:0] rem;
    logic [SENT_W-1:0]      sent_cnt;
    logic                   pop_c;
    logic                   arm_c;
    logic                   stall_c;

    logic [DATA_W-1:0]      x_q;
    logic                   x_valid_q;
    logic                   win_full_q;
    logic                   busy_q;
    logic                   done_q;
    logic                   underrun_q;

    logic                   fifo_wr;
    logic [DATA_W-1:0]      fifo_rd_data;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [CNT_W-1:0]       fifo_count;

    // Host can push whenever the buffer has room; a same-cycle pop does not help.
    assign bus.in_ready = (fifo_count != CNT_W'(DEPTH));
    assign fifo_wr      = bus.in_valid && !fifo_full;

    cs_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (fifo_wr),
        .wr_data (bus.in_data),
        .rd_en   (pop_c),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_d;
        end
    end

    // Next state plus pop / arm / stall strobes.
    always_comb begin
        state_d = state;
        pop_c   = 1'b0;
        arm_c   = 1'b0;
        stall_c = 1'b0;
        case (state)
            IDLE: begin
                if (bus.start) begin
                    if (bus.frame_len != '0) begin
                        state_d = PRIME;
                        arm_c   = 1'b1;
                    end else begin
                        state_d = FIN;
                    end
                end
            end
            PRIME, STREAM: begin
                if (!fifo_empty) begin
                    pop_c = 1'b1;
                    if (rem == FRAME_LEN_W'(1)) begin
                        state_d = FIN;
                    end else if ((state == PRIME) && (sent_cnt == SENT_W'(WIN - 1))) begin
                        state_d = STREAM;
                    end
                end else begin
                    stall_c = 1'b1;
                end
            end
            FIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame counters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rem        <= '0;
            sent_cnt   <= '0;
            x_q        <= '0;
            x_valid_q  <= 1'b0;
            win_full_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            underrun_q <= 1'b0;
        end else begin
            if (arm_c) begin
                rem      <= bus.frame_len;
                sent_cnt <= '0;
            end else if (pop_c) begin
                rem <= rem - FRAME_LEN_W'(1);
                if (sent_cnt != SENT_W'(WIN)) begin
                    sent_cnt <= sent_cnt + SENT_W'(1);
                end
            end

            x_valid_q <= pop_c;
            if (pop_c) begin
                x_q <= fifo_rd_data;
            end

            if (arm_c) begin
                underrun_q <= 1'b0;
            end else if (stall_c) begin
                underrun_q <= 1'b1;
            end

            if (state == FIN) begin
                win_full_q <= 1'b0;
            end else if (pop_c && (sent_cnt == SENT_W'(WIN - 1))) begin
                win_full_q <= 1'b1;
            end

            busy_q <= (state_d == PRIME) || (state_d == STREAM);
            done_q <= (state == FIN);
        end
    end

    assign bus.X        = x_q;
    assign bus.x_valid  = x_valid_q;
    assign bus.win_full = win_full_q;
    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.underrun = underrun_q;

endmodule
